seg_scan_display: RTL and testbench

- Parametrised successor to the 4-digit multiplexed seven-segment driver.
- Shows a DATA_W-bit unsigned value on DIGITS time-multiplexed common-anode digits, in either decimal or hex.
- Decimal conversion is an iterative double-dabble engine, with no dividers in the datapath.
- Adds leading-zero blanking, per-digit decimal points and overflow indication. Sits between a core result register and the board LED pins.

---
 rtl/seg_scan_pkg.sv | 36 +++
 rtl/seg_scan_display_bin2bcd.sv | 61 ++++++
 rtl/seg_scan_display.sv | 191 +++++++++++++++++++
 tb/tb_seg_scan_display.sv | 491 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared definitions for the multiplexed seven-segment display:
// segment glyphs, converter FSM states and elaboration-time helpers.
package seg_scan_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_DASH  = 8'hBF;

   // Active-low {dp,g,f,e,d,c,b,a}; entry n is the glyph for nibble n.
   localparam logic [15:0][7:0] SEG_DIGITS = {
      8'h8E, 8'h86, 8'hA1, 8'hC6,
      8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99,
      8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

   // Largest decimal value that fits in n digits.
   function automatic logic [31:0] pow10m1(input int n);
      logic [31:0] p;
      p = 32'd1;
      for (int i = 0; i < n; i++) begin
         p = p * 32'd10;
      end
      return p - 32'd1;
   endfunction

   function automatic logic [7:0] glyph(input logic [3:0] d);
      return SEG_DIGITS[d];
   endfunction

endpackage

// File: rtl/seg_scan_display_bin2bcd.sv
// Iterative double-dabble binary to BCD converter.
// One bit per cycle, DATA_W cycles per conversion after start.
module bin2bcd_seq
   import seg_scan_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DATA_W-1:0]     bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(DATA_W);

   logic [DATA_W-1:0] shreg;
   logic [CNT_W-1:0]  cnt;
   logic [BCD_W-1:0]  adj;

   // Add 3 to every nibble that would reach 10 or more after the shift.
   always_comb begin
      adj = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end else begin
            adj[4*i +: 4] = bcd[4*i +: 4];
         end
      end
   end

   assign done = busy && (cnt == CNT_W'(DATA_W - 1));

   // Shift engine; bits leaving the top of the BCD register are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg <= '0;
         bcd   <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
      end else if (start) begin
         shreg <= bin;
         bcd   <= '0;
         cnt   <= '0;
         busy  <= 1'b1;
      end else if (busy) begin
         bcd   <= {adj[BCD_W-2:0], shreg[DATA_W-1]};
         shreg <= shreg << 1;
         cnt   <= cnt + 1'b1;
         if (done) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed common-anode seven-segment driver with decimal/hex
// conversion, leading-zero blanking, decimal points and overflow dashes.
module seg_scan_display
   import seg_scan_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int DATA_W      = 16,
   parameter int REFRESH_DIV = 66666
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] data,
   input  logic              hex_mode,
   input  logic              blank_lz,
   input  logic [DIGITS-1:0] dp,
   output logic [7:0]        seg,
   output logic [DIGITS-1:0] sel,
   output logic              upd
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [31:0] DEC_MAX = pow10m1(DIGITS);
   localparam logic [31:0] HEX_MAX = 32'((64'd1 << BCD_W) - 64'd1);

   state_t state;
   state_t state_nxt;

   logic [31:0]             data_ext;
   logic [BCD_W-1:0]        hex_now;
   logic                    ovf_now;
   logic [BCD_W-1:0]        hex_val;
   logic                    hex_sel;
   logic                    ovf_cap;

   logic                    bcd_start;
   logic                    bcd_busy;
   logic                    bcd_done;
   logic [BCD_W-1:0]        bcd;

   logic [DIGITS-1:0][3:0]  disp;
   logic                    disp_vld;
   logic                    disp_ovf;

   logic [CNT_W-1:0]        cnt;
   logic [IDX_W-1:0]        idx;
   logic [DIGITS-1:0]       lz;
   logic                    run_zero;
   logic [7:0]              cur;

   assign data_ext = 32'(data);
   assign hex_now  = BCD_W'(data);
   assign ovf_now  = hex_mode ? (data_ext > HEX_MAX)
                              : (data_ext > DEC_MAX);

   bin2bcd_seq #(
      .DATA_W (DATA_W),
      .DIGITS (DIGITS)
   ) u_bcd (
      .clk   (clk),
      .rst_n (rst_n),
      .start (bcd_start),
      .bin   (data),
      .busy  (bcd_busy),
      .done  (bcd_done),
      .bcd   (bcd)
   );

   // Converter state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Converter next state: hex skips the shift phase entirely.
   always_comb begin
      state_nxt = state;
      bcd_start = 1'b0;
      unique case (state)
         IDLE: begin
            if (hex_mode) begin
               state_nxt = DONE;
            end else if (!bcd_busy) begin
               bcd_start = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (bcd_done) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Snapshot of mode, hex digits and overflow taken while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hex_val <= '0;
         hex_sel <= 1'b0;
         ovf_cap <= 1'b0;
      end else if (state == IDLE) begin
         hex_val <= hex_now;
         hex_sel <= hex_mode;
         ovf_cap <= ovf_now;
      end
   end

   // Display register is replaced in one step so no digit tears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp     <= '0;
         disp_vld <= 1'b0;
         disp_ovf <= 1'b0;
         upd      <= 1'b0;
      end else begin
         upd <= (state == DONE);
         if (state == DONE) begin
            disp     <= hex_sel ? hex_val : bcd;
            disp_vld <= 1'b1;
            disp_ovf <= ovf_cap;
         end
      end
   end

   // Refresh divider; the scan index steps once per slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         idx <= '0;
      end else if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
         cnt <= '0;
         if (idx == IDX_W'(DIGITS - 1)) begin
            idx <= '0;
         end else begin
            idx <= idx + 1'b1;
         end
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Digit i is a leading zero when it and all digits above are zero.
   always_comb begin
      run_zero = 1'b1;
      lz       = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         run_zero = run_zero && (disp[i] == 4'd0);
         lz[i]    = run_zero && (i != 0);
      end
   end

   // Glyph for the digit under scan; the point is overlaid last.
   always_comb begin
      cur = SEG_BLANK;
      if (!disp_vld) begin
         cur = SEG_BLANK;
      end else if (disp_ovf) begin
         cur = SEG_DASH;
      end else if (blank_lz && lz[idx]) begin
         cur = SEG_BLANK;
      end else begin
         cur = glyph(disp[idx]);
      end
      if (dp[idx]) begin
         cur[7] = 1'b0;
      end
   end

   // Registered pin drivers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg <= SEG_BLANK;
         sel <= '1;
      end else begin
         seg <= cur;
         sel <= ~(DIGITS'(1) << idx);
      end
   end

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display: directed scenarios plus
// randomized values checked against an arithmetic display model.
module tb_seg_scan_display;

   localparam int RD = 4;
   localparam int DW = 16;

   localparam logic [7:0] GLYPH [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   logic        clk;
   logic        rst_n;
   logic [15:0] data;
   logic        hex_mode;
   logic        blank_lz;
   logic [3:0]  dp;
   logic [7:0]  seg;
   logic [3:0]  sel;
   logic        upd;

   logic [19:0] data_w;
   logic        hex_w;
   logic        blank_w;
   logic [3:0]  dp_w;
   logic [7:0]  seg_w;
   logic [3:0]  sel_w;
   logic        upd_w;

   int checks;
   int errors;

   seg_scan_display #(
      .DIGITS      (4),
      .DATA_W      (DW),
      .REFRESH_DIV (RD)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .data     (data),
      .hex_mode (hex_mode),
      .blank_lz (blank_lz),
      .dp       (dp),
      .seg      (seg),
      .sel      (sel),
      .upd      (upd)
   );

   seg_scan_display #(
      .DIGITS      (4),
      .DATA_W      (20),
      .REFRESH_DIV (RD)
   ) dut_w (
      .clk      (clk),
      .rst_n    (rst_n),
      .data     (data_w),
      .hex_mode (hex_w),
      .blank_lz (blank_w),
      .dp       (dp_w),
      .seg      (seg_w),
      .sel      (sel_w),
      .upd      (upd_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // What digit k should show for value v, from the display rules.
   function automatic logic [7:0] model_seg(input longint v,
                                            input bit hx,
                                            input bit blz,
                                            input bit dpk,
                                            input int k);
      longint base;
      longint pw;
      longint lim;
      logic [7:0] g;
      base = hx ? 16 : 10;
      pw = 1;
      for (int i = 0; i < k; i++) pw = pw * base;
      lim = base * base * base * base;
      if (v >= lim) g = 8'hBF;
      else if (k > 0 && blz && v < pw) g = 8'hFF;
      else g = GLYPH[int'((v / pw) % base)];
      if (dpk) g[7] = 1'b0;
      return g;
   endfunction

   task automatic wait_upd(input int n);
      int seen;
      int t;
      seen = 0;
      t = 0;
      while (seen < n && t < 200) begin
         @(negedge clk);
         t++;
         if (upd) seen++;
      end
      checks++;
      if (seen < n) begin
         errors++;
         $display("FAIL wait_upd: saw %0d pulses, required %0d", seen, n);
      end
   endtask

   task automatic sync_slot0(output bit ok);
      logic [3:0] prev;
      int t;
      ok = 1'b0;
      prev = sel;
      t = 0;
      while (!ok && t < 64) begin
         @(negedge clk);
         t++;
         if (sel == 4'b1110 && prev != 4'b1110) ok = 1'b1;
         prev = sel;
      end
   endtask

   task automatic grab_frame(output logic [3:0][7:0] f,
                             output logic [3:0][7:0] fw,
                             output logic [3:0][3:0] s);
      bit ok;
      sync_slot0(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL sync: no digit-0 slot, sel=%b required 1110", sel);
      end
      for (int k = 0; k < 4; k++) begin
         f[k] = seg;
         fw[k] = seg_w;
         s[k] = sel;
         repeat (RD) @(negedge clk);
      end
   endtask

   task automatic test_reset;
      int cyc;
      bit got;
      bit blank_ok;
      rst_n = 1'b0;
      data = 16'd1234;
      hex_mode = 1'b0;
      blank_lz = 1'b0;
      dp = 4'b0000;
      data_w = '0;
      hex_w = 1'b1;
      blank_w = 1'b0;
      dp_w = 4'b0000;
      repeat (3) @(negedge clk);
      checks++;
      if (seg !== 8'hFF || sel !== 4'hF || upd !== 1'b0) begin
         errors++;
         $display("FAIL reset_init: seg=%h sel=%b upd=%b required FF 1111 0", seg, sel, upd);
      end
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (seg !== 8'hFF || sel !== 4'hF || upd !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: seg=%h sel=%b upd=%b required FF 1111 0", seg, sel, upd);
      end
      @(negedge clk);
      rst_n = 1'b1;
      cyc = 0;
      got = 1'b0;
      blank_ok = 1'b1;
      while (!got && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (seg !== 8'hFF) blank_ok = 1'b0;
         if (upd) got = 1'b1;
      end
      checks++;
      if (!got || cyc != DW + 2) begin
         errors++;
         $display("FAIL first_upd: after %0d cycles (seen=%0d), required %0d", cyc, got, DW + 2);
      end
      checks++;
      if (!blank_ok) begin
         errors++;
         $display("FAIL pre_load_blank: seg=%h before first update, required FF", seg);
      end
   endtask

   task automatic test_scan_1234;
      logic [3:0][7:0] exp;
      logic [3:0] one;
      logic [3:0] es;
      logic [3:0] cur;
      int len;
      int cyc;
      bit ok;
      exp = {8'hF9, 8'hA4, 8'hB0, 8'h99};
      one = 4'b0001;
      data = 16'd1234;
      hex_mode = 1'b0;
      blank_lz = 1'b0;
      dp = 4'b0000;
      wait_upd(2);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!upd && cyc < 60);
      checks++;
      if (cyc != DW + 2) begin
         errors++;
         $display("FAIL dec_period: %0d cycles, required %0d", cyc, DW + 2);
      end
      sync_slot0(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL scan_sync: sel=%b required 1110", sel);
      end
      for (int n = 0; n < 8; n++) begin
         es = ~(one << (n % 4));
         checks++;
         if (sel !== es) begin
            errors++;
            $display("FAIL scan_sel slot %0d: sel=%b required %b", n, sel, es);
         end
         checks++;
         if (seg !== exp[n % 4]) begin
            errors++;
            $display("FAIL scan_seg slot %0d: seg=%h required %h", n, seg, exp[n % 4]);
         end
         cur = sel;
         len = 0;
         do begin
            @(negedge clk);
            len++;
         end while (sel == cur && len < 12);
         checks++;
         if (len != RD) begin
            errors++;
            $display("FAIL scan_len slot %0d: %0d cycles, required %0d", n, len, RD);
         end
      end
   endtask

   task automatic test_blanking;
      logic [15:0] vals [4];
      bit blzs [4];
      logic [3:0][7:0] exps [4];
      logic [3:0][7:0] f;
      logic [3:0][7:0] fw;
      logic [3:0][3:0] s;
      vals[0] = 16'd7;    blzs[0] = 1'b1; exps[0] = {8'hFF, 8'hFF, 8'hFF, 8'hF8};
      vals[1] = 16'd7;    blzs[1] = 1'b0; exps[1] = {8'hC0, 8'hC0, 8'hC0, 8'hF8};
      vals[2] = 16'd0;    blzs[2] = 1'b1; exps[2] = {8'hFF, 8'hFF, 8'hFF, 8'hC0};
      vals[3] = 16'd1005; blzs[3] = 1'b1; exps[3] = {8'hF9, 8'hC0, 8'hC0, 8'h92};
      hex_mode = 1'b0;
      dp = 4'b0000;
      for (int c = 0; c < 4; c++) begin
         data = vals[c];
         blank_lz = blzs[c];
         wait_upd(2);
         grab_frame(f, fw, s);
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (f[k] !== exps[c][k]) begin
               errors++;
               $display("FAIL blank val=%0d blz=%0d digit %0d: seg=%h required %h",
                        vals[c], blzs[c], k, f[k], exps[c][k]);
            end
         end
      end
   endtask

   task automatic test_overflow;
      logic [3:0][7:0] f;
      logic [3:0][7:0] fw;
      logic [3:0][3:0] s;
      hex_mode = 1'b0;
      dp = 4'b0000;
      blank_lz = 1'b1;
      data = 16'd10000;
      wait_upd(2);
      grab_frame(f, fw, s);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (f[k] !== 8'hBF) begin
            errors++;
            $display("FAIL ovf_10000 digit %0d: seg=%h required BF", k, f[k]);
         end
      end
      data = 16'd9999;
      wait_upd(2);
      grab_frame(f, fw, s);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (f[k] !== 8'h90) begin
            errors++;
            $display("FAIL max_9999 digit %0d: seg=%h required 90", k, f[k]);
         end
      end
   endtask

   task automatic test_hex;
      logic [3:0][7:0] f;
      logic [3:0][7:0] fw;
      logic [3:0][3:0] s;
      logic [3:0][7:0] exp;
      int cyc;
      exp = {8'h83, 8'h86, 8'h86, 8'h8E};
      hex_mode = 1'b1;
      blank_lz = 1'b0;
      dp = 4'b0000;
      data = 16'hBEEF;
      wait_upd(2);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!upd && cyc < 20);
      checks++;
      if (cyc != 2) begin
         errors++;
         $display("FAIL hex_period: %0d cycles, required 2", cyc);
      end
      grab_frame(f, fw, s);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (f[k] !== exp[k]) begin
            errors++;
            $display("FAIL hex_beef digit %0d: seg=%h required %h", k, f[k], exp[k]);
         end
      end
   endtask

   task automatic test_hex_wide;
      logic [3:0][7:0] f;
      logic [3:0][7:0] fw;
      logic [3:0][3:0] s;
      int cyc;
      hex_w = 1'b1;
      blank_w = 1'b0;
      dp_w = 4'b0000;
      data_w = 20'h10000;
      wait_upd(2);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!upd_w && cyc < 20);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!upd_w && cyc < 20);
      checks++;
      if (cyc != 2) begin
         errors++;
         $display("FAIL wide_period: %0d cycles, required 2", cyc);
      end
      grab_frame(f, fw, s);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (fw[k] !== 8'hBF) begin
            errors++;
            $display("FAIL wide_ovf digit %0d: seg=%h required BF", k, fw[k]);
         end
      end
      checks++;
      if (sel_w !== sel) begin
         errors++;
         $display("FAIL wide_sel: sel=%b required %b", sel_w, sel);
      end
      data_w = 20'h0FFFF;
      wait_upd(2);
      grab_frame(f, fw, s);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (fw[k] !== 8'h8E) begin
            errors++;
            $display("FAIL wide_ffff digit %0d: seg=%h required 8E", k, fw[k]);
         end
      end
   endtask

   task automatic test_dp;
      logic [3:0][7:0] f;
      logic [3:0][7:0] fw;
      logic [3:0][3:0] s;
      logic [3:0][7:0] exp;
      exp = {8'hF9, 8'h24, 8'hB0, 8'h99};
      hex_mode = 1'b0;
      blank_lz = 1'b0;
      dp = 4'b0100;
      data = 16'd1234;
      wait_upd(2);
      grab_frame(f, fw, s);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (f[k] !== exp[k]) begin
            errors++;
            $display("FAIL dp digit %0d: seg=%h required %h", k, f[k], exp[k]);
         end
      end
      dp = 4'b0000;
   endtask

   task automatic test_back_to_back;
      int bad;
      logic [7:0] last;
      hex_mode = 1'b0;
      blank_lz = 1'b0;
      dp = 4'b0000;
      data = 16'd1111;
      wait_upd(2);
      repeat (4) @(negedge clk);
      data = 16'd2345;
      hex_mode = 1'b1;
      wait_upd(1);
      data = 16'd1111;
      hex_mode = 1'b0;
      bad = 0;
      last = 8'hF9;
      for (int c = 0; c < DW + 1; c++) begin
         @(negedge clk);
         if (seg !== 8'hF9) begin
            bad++;
            last = seg;
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL mid_shift_change: %0d cycles showed seg=%h, required F9", bad, last);
      end
   endtask

   task automatic test_random;
      logic [3:0][7:0] f;
      logic [3:0][7:0] fw;
      logic [3:0][3:0] s;
      logic [7:0] e;
      int r;
      for (int it = 0; it < 30; it++) begin
         hex_mode = 1'($urandom_range(0, 1));
         blank_lz = 1'($urandom_range(0, 1));
         dp = 4'($urandom_range(0, 15));
         r = $urandom_range(0, 3);
         if (hex_mode) begin
            data = 16'($urandom_range(0, 65535));
            if (r == 0) data = data & 16'h00FF;
         end else begin
            case (r)
               0: data = 16'($urandom_range(0, 99));
               1: data = 16'($urandom_range(0, 9999));
               2: data = 16'($urandom_range(10000, 65535));
               default: data = 16'($urandom_range(0, 65535));
            endcase
         end
         wait_upd(2);
         grab_frame(f, fw, s);
         for (int k = 0; k < 4; k++) begin
            e = model_seg(longint'(data), hex_mode, blank_lz, dp[k], k);
            checks++;
            if (f[k] !== e) begin
               errors++;
               $display("FAIL random v=%0d hex=%0d blz=%0d dp=%b digit %0d: seg=%h required %h",
                        data, hex_mode, blank_lz, dp, k, f[k], e);
            end
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset;
      test_scan_1234;
      test_blanking;
      test_overflow;
      test_hex;
      test_hex_wide;
      test_dp;
      test_back_to_back;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
